arbitro_puerto_a1: RTL

- Sequences and shares read port a1 of the register bank between three requesters: 0 = decode (rs field), 1 = writeback/forwarding check, 2 = debug/monitor.
- Drives the 2-bit select of the a1 input multiplexer and issues one-hot grants and read-complete acknowledges.
- Selects one requester per transaction and holds the select stable for the whole register-bank read latency.
- Sits between the control unit and the bank's a1 input multiplexer.

---
 rtl/arbitro_puerto_a1_pkg.sv | 29 ++
 rtl/arbitro_puerto_a1_if.sv | 14 +
 rtl/arbitro_rr3.sv | 42 ++++
 rtl/arbitro_puerto_a1.sv | 120 ++++++++++++
 4 files changed

// File: rtl/arbitro_puerto_a1_pkg.sv
// Shared definitions for the a1 read-port arbiter: FSM states, mux select codes, requester indices.
package arbitro_puerto_a1_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    localparam logic [1:0] SEL_REQ0 = 2'b00;
    localparam logic [1:0] SEL_REQ1 = 2'b01;
    localparam logic [1:0] SEL_REQ2 = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    localparam logic [1:0] REQ_DEC = 2'd0;
    localparam logic [1:0] REQ_WB  = 2'd1;
    localparam logic [1:0] REQ_DBG = 2'd2;
    localparam int         N_REQ   = 3;

    function automatic logic [2:0] onehot3(input logic [1:0] idx);
        return 3'b001 << idx;
    endfunction

    // Requester index after idx, wrapping 2 -> 0.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx >= REQ_DBG) ? REQ_DEC : idx + 2'd1;
    endfunction

endpackage

// File: rtl/arbitro_puerto_a1_if.sv
// Request/grant bundle between the control unit and the a1 port arbiter.
interface arbitro_puerto_a1_if;

    logic [2:0] req;
    logic       hold;
    logic [1:0] ctrl;
    logic [2:0] gnt;
    logic [2:0] ack;
    logic       busy;

    modport master (output req, hold, input ctrl, gnt, ack, busy);
    modport slave  (input req, hold, output ctrl, gnt, ack, busy);

endinterface

// File: rtl/arbitro_rr3.sv
// Combinational 3-way picker: round-robin from rr_ptr, or fixed priority 0 > 1 > 2
// when ARB_A1_FIXED_PRIO_EN is defined.
module arbitro_rr3
    import arbitro_puerto_a1_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] rr_ptr,
    output logic       valid,
    output logic [1:0] winner
);

    assign valid = |req;

`ifdef ARB_A1_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^rr_ptr;

    always_comb begin
        winner = REQ_DEC;
        if (req[0])      winner = REQ_DEC;
        else if (req[1]) winner = REQ_WB;
        else if (req[2]) winner = REQ_DBG;
    end
`else
    logic [1:0] idx;
    logic       found;

    always_comb begin
        winner = REQ_DEC;
        found  = 1'b0;
        idx    = (rr_ptr > REQ_DBG) ? REQ_DEC : rr_ptr;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
            idx = next_idx(idx);
        end
    end
`endif

endmodule

// File: rtl/arbitro_puerto_a1.sv
// Arbiter for register-bank read port a1: one owner per transaction, select held for the read
// latency, one-cycle ack. Define ARB_A1_FIXED_PRIO_EN for fixed priority instead of round-robin.
module arbitro_puerto_a1
    import arbitro_puerto_a1_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    arbitro_puerto_a1_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LOAD = (RD_LAT > 0) ? CNT_W'(RD_LAT - 1) : '0;

    arb_state_e       state_q, state_d;
    logic [1:0]       ctrl_q, ctrl_d;
    logic [2:0]       gnt_q, gnt_d;
    logic [2:0]       ack_q, ack_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       rr_ptr;
    logic [1:0]       pick_idx;
    logic             pick_vld;

`ifdef ARB_A1_FIXED_PRIO_EN
    assign rr_ptr = REQ_DEC;
`else
    logic [1:0] rr_q, rr_d;
    assign rr_ptr = rr_q;
`endif

    arbitro_rr3 u_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .valid  (pick_vld),
        .winner (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ctrl_q  <= SEL_NONE;
            gnt_q   <= '0;
            ack_q   <= '0;
            cnt_q   <= '0;
`ifndef ARB_A1_FIXED_PRIO_EN
            rr_q    <= REQ_DEC;
`endif
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            cnt_q   <= cnt_d;
`ifndef ARB_A1_FIXED_PRIO_EN
            rr_q    <= rr_d;
`endif
        end
    end

    // The ack cycle is spent in WAIT with grant still held; leaving WAIT drops the select to
    // SEL_NONE, which gives the mandatory idle bubble before the next arbitration.
    always_comb begin
        state_d = state_q;
        ctrl_d  = ctrl_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        cnt_d   = cnt_q;
`ifndef ARB_A1_FIXED_PRIO_EN
        rr_d    = rr_q;
`endif
        unique case (state_q)
            IDLE: begin
                ctrl_d = SEL_NONE;
                gnt_d  = '0;
                if (!bus.hold && pick_vld) begin
                    ctrl_d  = pick_idx;
                    gnt_d   = onehot3(pick_idx);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
                if (RD_LAT == 0) begin
                    ack_d = gnt_q;
`ifndef ARB_A1_FIXED_PRIO_EN
                    rr_d  = next_idx(ctrl_q);
`endif
                end else begin
                    cnt_d = CNT_LOAD;
                end
            end
            WAIT: begin
                if (ack_q != '0) begin
                    state_d = IDLE;
                    ctrl_d  = SEL_NONE;
                    gnt_d   = '0;
                end else if (cnt_q == '0) begin
                    ack_d = gnt_q;
`ifndef ARB_A1_FIXED_PRIO_EN
                    rr_d  = next_idx(ctrl_q);
`endif
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                ctrl_d  = SEL_NONE;
                gnt_d   = '0;
            end
        endcase
    end

    assign bus.ctrl = ctrl_q;
    assign bus.gnt  = gnt_q;
    assign bus.ack  = ack_q;
    assign bus.busy = (state_q != IDLE);

endmodule
